// File: rtl/module_codificador_secded_pkg.sv
// Shared SECDED(8,4) definitions: FSM states, codeword positions and the
// helpers that build injection masks and parity.
package pkg_hamming;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CODIFICA = 2'd1,
        INYECTA  = 2'd2,
        ENVIA    = 2'd3
    } estado_t;

    // Hamming positions are 1-based; bit index in the codeword is position-1.
    localparam logic [3:0] POS_P1  = 4'd1;
    localparam logic [3:0] POS_P2  = 4'd2;
    localparam logic [3:0] POS_D1  = 4'd3;
    localparam logic [3:0] POS_P3  = 4'd4;
    localparam logic [3:0] POS_D2  = 4'd5;
    localparam logic [3:0] POS_D3  = 4'd6;
    localparam logic [3:0] POS_D4  = 4'd7;
    localparam logic [3:0] POS_P0  = 4'd8;
    localparam logic [3:0] POS_MIN = 4'd1;
    localparam logic [3:0] POS_MAX = 4'd8;

    function automatic logic [7:0] mascara_pos(input logic [3:0] pos);
        logic [7:0] m;
        m = 8'h00;
        if ((pos >= POS_MIN) && (pos <= POS_MAX)) begin
            m = 8'h01 << (pos - 4'd1);
        end else begin
            m = 8'h00;
        end
        return m;
    endfunction

    function automatic logic paridad7(input logic [6:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/module_codificador_secded_comb.sv
// Combinational SECDED(8,4) encoder: Hamming(7,4) in positions 1..7 and an
// overall even-parity bit in position 8.
module module_codificador_comb
    import pkg_hamming::*;
(
    input  logic [3:0] dato,
    output logic [7:0] palabra
);

    logic d1_s, d2_s, d3_s, d4_s;
    logic p1_s, p2_s, p3_s;
    logic [6:0] hamming7_s;

    assign d1_s = dato[0];
    assign d2_s = dato[1];
    assign d3_s = dato[2];
    assign d4_s = dato[3];

    assign p1_s = d1_s ^ d2_s ^ d4_s;
    assign p2_s = d1_s ^ d3_s ^ d4_s;
    assign p3_s = d2_s ^ d3_s ^ d4_s;

    // Builds positions 1..7 in order p1 p2 d1 p3 d2 d3 d4.
    always_comb begin
        hamming7_s               = 7'b000_0000;
        hamming7_s[POS_P1-4'd1]  = p1_s;
        hamming7_s[POS_P2-4'd1]  = p2_s;
        hamming7_s[POS_D1-4'd1]  = d1_s;
        hamming7_s[POS_P3-4'd1]  = p3_s;
        hamming7_s[POS_D2-4'd1]  = d2_s;
        hamming7_s[POS_D3-4'd1]  = d3_s;
        hamming7_s[POS_D4-4'd1]  = d4_s;
    end

    assign palabra = {paridad7(hamming7_s), hamming7_s};

endmodule

// File: rtl/module_codificador_secded.sv
// Transmit-side SECDED encoder: captures a data word on carga, encodes it,
// optionally flips up to two bits and holds it under a valid/ready handshake.
module module_codificador_secded
    import pkg_hamming::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       carga,
    input  logic [3:0] dato,
    input  logic [3:0] err_pos_a,
    input  logic [3:0] err_pos_b,
    input  logic       listo,
    output logic [7:0] palabra_cod,
    output logic       valido,
    output logic       ocupado,
    output logic [7:0] mascara_err,
    output logic [3:0] contador_tx
);

    estado_t    estado_r, estado_sig_s;
    logic [3:0] dato_r, pos_a_r, pos_b_r;
    logic [7:0] limpio_s, limpio_r, mascara_s;
    logic [7:0] palabra_r, mascara_r;
    logic       valido_r, ocupado_r;
    logic [3:0] contador_r;
    logic       captura_s, codifica_s, inyecta_s, transfiere_s;

    module_codificador_comb u_codificador (
        .dato    (dato_r),
        .palabra (limpio_s)
    );

    // OR rather than XOR so a duplicated position flips a single bit.
    assign mascara_s = mascara_pos(pos_a_r) | mascara_pos(pos_b_r);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r <= IDLE;
        end else begin
            estado_r <= estado_sig_s;
        end
    end

    // Next-state logic.
    always_comb begin
        estado_sig_s = estado_r;
        case (estado_r)
            IDLE: begin
                if (carga) begin
                    estado_sig_s = CODIFICA;
                end else begin
                    estado_sig_s = IDLE;
                end
            end
            CODIFICA: estado_sig_s = INYECTA;
            INYECTA:  estado_sig_s = ENVIA;
            ENVIA: begin
                if (valido_r && listo) begin
                    estado_sig_s = IDLE;
                end else begin
                    estado_sig_s = ENVIA;
                end
            end
            default: estado_sig_s = IDLE;
        endcase
    end

    // Per-state datapath enables.
    always_comb begin
        captura_s    = 1'b0;
        codifica_s   = 1'b0;
        inyecta_s    = 1'b0;
        transfiere_s = 1'b0;
        case (estado_r)
            IDLE:     captura_s    = carga;
            CODIFICA: codifica_s   = 1'b1;
            INYECTA:  inyecta_s    = 1'b1;
            ENVIA:    transfiere_s = valido_r & listo;
            default: begin
                captura_s    = 1'b0;
                codifica_s   = 1'b0;
                inyecta_s    = 1'b0;
                transfiere_s = 1'b0;
            end
        endcase
    end

    // Input capture: the word in flight is frozen from the load cycle on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dato_r  <= 4'd0;
            pos_a_r <= 4'd0;
            pos_b_r <= 4'd0;
        end else if (captura_s) begin
            dato_r  <= dato;
            pos_a_r <= err_pos_a;
            pos_b_r <= err_pos_b;
        end
    end

    // Clean codeword register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            limpio_r <= 8'h00;
        end else if (codifica_s) begin
            limpio_r <= limpio_s;
        end
    end

    // Injected word and mask; kept after transfer until the next injection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            palabra_r <= 8'h00;
            mascara_r <= 8'h00;
        end else if (inyecta_s) begin
            palabra_r <= limpio_r ^ mascara_s;
            mascara_r <= mascara_s;
        end
    end

    // Handshake valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valido_r <= 1'b0;
        end else if (inyecta_s) begin
            valido_r <= 1'b1;
        end else if (transfiere_s) begin
            valido_r <= 1'b0;
        end
    end

    // Busy flag, registered from the next state so it tracks state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ocupado_r <= 1'b0;
        end else begin
            ocupado_r <= (estado_sig_s != IDLE);
        end
    end

    // Accepted-word counter, wraps modulo 16.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contador_r <= 4'd0;
        end else if (transfiere_s) begin
            contador_r <= contador_r + 4'd1;
        end
    end

    assign palabra_cod = palabra_r;
    assign mascara_err = mascara_r;
    assign valido      = valido_r;
    assign ocupado     = ocupado_r;
    assign contador_tx = contador_r;

endmodule

// File: tb/tb_module_codificador_secded.sv
// Directed self-checking bench for module_codificador_secded.
module tb_module_codificador_secded;

    logic       clk;
    logic       rst_n;
    logic       carga;
    logic [3:0] dato;
    logic [3:0] err_pos_a;
    logic [3:0] err_pos_b;
    logic       listo;
    logic [7:0] palabra_cod;
    logic       valido;
    logic       ocupado;
    logic [7:0] mascara_err;
    logic [3:0] contador_tx;

    logic [3:0] g_dato;
    logic [7:0] g_palabra;

    int         checks;
    int         errors;
    logic [3:0] exp_cnt;

    module_codificador_secded dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .carga       (carga),
        .dato        (dato),
        .err_pos_a   (err_pos_a),
        .err_pos_b   (err_pos_b),
        .listo       (listo),
        .palabra_cod (palabra_cod),
        .valido      (valido),
        .ocupado     (ocupado),
        .mascara_err (mascara_err),
        .contador_tx (contador_tx)
    );

    module_codificador_comb u_gold (
        .dato    (g_dato),
        .palabra (g_palabra)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bench_mask(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] m;
        m = 8'h00;
        for (int n = 1; n <= 8; n++) begin
            if ((a == n[3:0]) || (b == n[3:0])) m[n-1] = 1'b1;
        end
        return m;
    endfunction

    // Sends one word; called just after a rising edge with the DUT in IDLE.
    task automatic run_word(input string tag, input logic [3:0] d, input logic [3:0] a,
                            input logic [3:0] b, input logic [7:0] exp_w,
                            input logic [7:0] exp_m, input int stall, input bit noisy);
        dato      = d;
        err_pos_a = a;
        err_pos_b = b;
        carga     = 1'b1;
        listo     = (stall == 0);
        @(posedge clk); #1;
        carga     = 1'b0;
        dato      = ~d;
        err_pos_a = 4'd5;
        err_pos_b = 4'd6;
        chk({tag, "_ocupado_k"}, {7'd0, ocupado}, 8'd1);
        chk({tag, "_valido_k"}, {7'd0, valido}, 8'd0);
        @(posedge clk); #1;
        chk({tag, "_valido_k1"}, {7'd0, valido}, 8'd0);
        @(posedge clk); #1;
        chk({tag, "_valido_k2"}, {7'd0, valido}, 8'd1);
        chk({tag, "_palabra"}, palabra_cod, exp_w);
        chk({tag, "_mascara"}, mascara_err, exp_m);
        for (int i = 0; i < stall; i++) begin
            if (noisy) begin
                carga = ~carga;
                dato  = 4'($urandom_range(0, 15));
            end
            @(posedge clk); #1;
            chk({tag, "_hold_palabra"}, palabra_cod, exp_w);
            chk({tag, "_hold_valido"}, {7'd0, valido}, 8'd1);
        end
        carga = 1'b0;
        listo = 1'b1;
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 4'd1;
        listo   = 1'b0;
        chk({tag, "_valido_tx"}, {7'd0, valido}, 8'd0);
        chk({tag, "_ocupado_tx"}, {7'd0, ocupado}, 8'd0);
        chk({tag, "_contador"}, {4'd0, contador_tx}, {4'd0, exp_cnt});
        chk({tag, "_palabra_kept"}, palabra_cod, exp_w);
        @(posedge clk); #1;
        chk({tag, "_idle_after"}, {7'd0, ocupado}, 8'd0);
    endtask

    initial begin
        logic [3:0] rd, ra, rb;
        checks    = 0;
        errors    = 0;
        exp_cnt   = 4'd0;
        rst_n     = 1'b0;
        carga     = 1'b0;
        dato      = 4'd0;
        err_pos_a = 4'd0;
        err_pos_b = 4'd0;
        listo     = 1'b0;
        g_dato    = 4'd0;
        #12;
        chk("rst_palabra", palabra_cod, 8'h00);
        chk("rst_valido", {7'd0, valido}, 8'd0);
        chk("rst_ocupado", {7'd0, ocupado}, 8'd0);
        chk("rst_mascara", mascara_err, 8'h00);
        chk("rst_contador", {4'd0, contador_tx}, 8'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Park a word in ENVIA, then reset asynchronously between edges.
        dato = 4'hB; err_pos_a = 4'd3; carga = 1'b1;
        @(posedge clk); #1;
        carga = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_valido_pre", {7'd0, valido}, 8'd1);
        chk("mid_palabra_pre", palabra_cod, 8'h51);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_palabra", palabra_cod, 8'h00);
        chk("mid_rst_valido", {7'd0, valido}, 8'd0);
        chk("mid_rst_ocupado", {7'd0, ocupado}, 8'd0);
        chk("mid_rst_mascara", mascara_err, 8'h00);
        #1;
        rst_n = 1'b1;
        err_pos_a = 4'd0;
        @(posedge clk); #1;
        chk("mid_rst_idle", {7'd0, ocupado}, 8'd0);

        run_word("clean_b", 4'hB, 4'd0, 4'd0, 8'h55, 8'h00, 0, 1'b0);
        run_word("clean_0", 4'h0, 4'd0, 4'd0, 8'h00, 8'h00, 0, 1'b0);
        run_word("clean_f", 4'hF, 4'd0, 4'd0, 8'hFF, 8'h00, 0, 1'b0);
        run_word("single3", 4'hB, 4'd3, 4'd0, 8'h51, 8'h04, 0, 1'b0);
        run_word("double18", 4'hB, 4'd1, 4'd8, 8'hD4, 8'h81, 0, 1'b0);
        run_word("dup2", 4'hB, 4'd2, 4'd2, 8'h57, 8'h02, 0, 1'b0);
        run_word("pos12", 4'hB, 4'd12, 4'd0, 8'h55, 8'h00, 0, 1'b0);
        run_word("backpr", 4'h6, 4'd0, 4'd9, 8'h33, 8'h00, 10, 1'b1);

        for (int i = 0; i < 9; i++) begin
            rd = 4'($urandom_range(0, 15));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            g_dato = rd;
            #1;
            run_word("rand", rd, ra, rb, g_palabra ^ bench_mask(ra, rb),
                     bench_mask(ra, rb), int'($urandom_range(0, 3)), 1'b0);
        end
        chk("wrap17", {4'd0, contador_tx}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
